// File: rtl/sram1024x18_fifo_ctrl.sv
// rtl/sram1024x18_fifo_ctrl.sv - single-clock FWFT FIFO controller over the sram1024x18 dual-port RAM
//
// Purpose:
//   Port A of the RAM is the write port and port B is the read port.
//   A 2-entry output buffer hides the RAM's 1-cycle registered read latency.
//   This lets the FIFO accept one push and deliver one pop every cycle.
//
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_wr_valid/o_wr_ready/i_wr_data    push interface (valid/ready)
//   o_rd_valid/i_rd_ready/o_rd_data    pop interface (first-word fall-through)
//   o_level, o_full, o_empty           registered occupancy status
//   o_ram_*_a                          RAM port A (write)
//   o_ram_*_b, i_ram_rdata_b           RAM port B (read)
module sram1024x18_fifo_ctrl #(
  parameter int DEPTH = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [17:0] i_wr_data,
  output logic        o_rd_valid,
  input  logic        i_rd_ready,
  output logic [17:0] o_rd_data,
  output logic [10:0] o_level,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_ram_cen_a,
  output logic        o_ram_wen_a,
  output logic [9:0]  o_ram_addr_a,
  output logic [17:0] o_ram_wmsk_a,
  output logic [17:0] o_ram_wdata_a,
  output logic        o_ram_cen_b,
  output logic        o_ram_wen_b,
  output logic [9:0]  o_ram_addr_b,
  output logic [17:0] o_ram_wmsk_b,
  output logic [17:0] o_ram_wdata_b,
  input  logic [17:0] i_ram_rdata_b
);

  localparam logic [9:0]  PTR_LAST = 10'(DEPTH - 1);
  localparam logic [10:0] LVL_FULL = 11'(DEPTH);

  logic [9:0]  r_wptr;
  logic [9:0]  r_rptr;
  logic [10:0] r_ram_cnt;
  logic        r_inflight;
  logic [1:0]  r_ob_cnt;
  logic [17:0] r_ob0;
  logic [17:0] r_ob1;
  logic [10:0] r_level;

  logic        w_full_q;
  logic        w_push;
  logic        w_pop;
  logic        w_issue;
  logic [2:0]  w_ob_demand;

  assign w_full_q   = (r_level == LVL_FULL);

  // Status outputs are forced to their idle values while reset is held.
  assign o_full     = !i_rst & w_full_q;
  assign o_empty    = i_rst | (r_level == 11'd0);
  assign o_level    = i_rst ? 11'd0 : r_level;

  assign o_wr_ready = !w_full_q & !i_rst;
  assign w_push     = i_wr_valid & o_wr_ready;

  assign o_rd_valid = !i_rst & (r_ob_cnt != 2'd0);
  assign o_rd_data  = i_rst ? 18'd0 : r_ob0;
  assign w_pop      = o_rd_valid & i_rd_ready;

  // Slots the output buffer will hold after this edge if nothing new is issued.
  // A pop only happens with ob_cnt >= 1, so the subtraction cannot underflow.
  assign w_ob_demand = {1'b0, r_ob_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = !i_rst & (r_ram_cnt != 11'd0) & (w_ob_demand < 3'd2);

  assign o_ram_cen_a   = !w_push;
  assign o_ram_wen_a   = !w_push;
  assign o_ram_addr_a  = r_wptr;
  assign o_ram_wmsk_a  = 18'h00000;
  assign o_ram_wdata_a = i_wr_data;

  assign o_ram_cen_b   = !w_issue;
  assign o_ram_wen_b   = 1'b1;
  assign o_ram_addr_b  = r_rptr;
  assign o_ram_wmsk_b  = 18'h3FFFF;
  assign o_ram_wdata_b = 18'h00000;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr     <= 10'd0;
      r_rptr     <= 10'd0;
      r_ram_cnt  <= 11'd0;
      r_inflight <= 1'b0;
      r_ob_cnt   <= 2'd0;
      r_ob0      <= 18'd0;
      r_ob1      <= 18'd0;
      r_level    <= 11'd0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PTR_LAST) ? 10'd0 : r_wptr + 10'd1;
      end
      if (w_issue) begin
        r_rptr <= (r_rptr == PTR_LAST) ? 10'd0 : r_rptr + 10'd1;
      end
      r_inflight <= w_issue;
      r_ram_cnt  <= r_ram_cnt + {10'd0, w_push} - {10'd0, w_issue};
      r_level    <= r_level + {10'd0, w_push} - {10'd0, w_pop};

      // The output buffer is a 2-entry shift queue with r_ob0 as the head.
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_ob_cnt == 2'd0) begin
            r_ob0 <= i_ram_rdata_b;
          end else begin
            r_ob1 <= i_ram_rdata_b;
          end
          r_ob_cnt <= r_ob_cnt + 2'd1;
        end
        2'b01: begin
          r_ob0    <= r_ob1;
          r_ob_cnt <= r_ob_cnt - 2'd1;
        end
        2'b11: begin
          // The capture and the pop cancel out, so the count is unchanged.
          if (r_ob_cnt == 2'd2) begin
            r_ob0 <= r_ob1;
            r_ob1 <= i_ram_rdata_b;
          end else begin
            r_ob0 <= i_ram_rdata_b;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram1024x18_fifo_ctrl.sv
// tb/tb_sram1024x18_fifo_ctrl.sv - testbench for sram1024x18_fifo_ctrl with DEPTH=1024 and DEPTH=10
module tb_sram1024x18_fifo_ctrl;

  localparam int DA = 1024;
  localparam int DB = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [17:0] wr_data = 18'd0;
  logic        rd_ready = 1'b0;

  logic        a_wr_ready, a_rd_valid, a_full, a_empty;
  logic [17:0] a_rd_data;
  logic [10:0] a_level;
  logic        a_cen_a, a_wen_a, a_cen_b, a_wen_b;
  logic [9:0]  a_addr_a, a_addr_b;
  logic [17:0] a_wmsk_a, a_wdata_a, a_wmsk_b, a_wdata_b, a_rdata_b;

  logic        b_wr_ready, b_rd_valid, b_full, b_empty;
  logic [17:0] b_rd_data;
  logic [10:0] b_level;
  logic        b_cen_a, b_wen_a, b_cen_b, b_wen_b;
  logic [9:0]  b_addr_a, b_addr_b;
  logic [17:0] b_wmsk_a, b_wdata_a, b_wmsk_b, b_wdata_b, b_rdata_b;

  logic [17:0] mem_a [0:1023];
  logic [17:0] mem_b [0:1023];

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] qa[$];
  logic [17:0] qb[$];

  always #5 clk = ~clk;

  sram1024x18_fifo_ctrl #(.DEPTH(DA)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_wr_valid(wr_valid), .o_wr_ready(a_wr_ready), .i_wr_data(wr_data),
    .o_rd_valid(a_rd_valid), .i_rd_ready(rd_ready), .o_rd_data(a_rd_data),
    .o_level(a_level), .o_full(a_full), .o_empty(a_empty),
    .o_ram_cen_a(a_cen_a), .o_ram_wen_a(a_wen_a), .o_ram_addr_a(a_addr_a),
    .o_ram_wmsk_a(a_wmsk_a), .o_ram_wdata_a(a_wdata_a),
    .o_ram_cen_b(a_cen_b), .o_ram_wen_b(a_wen_b), .o_ram_addr_b(a_addr_b),
    .o_ram_wmsk_b(a_wmsk_b), .o_ram_wdata_b(a_wdata_b), .i_ram_rdata_b(a_rdata_b)
  );

  sram1024x18_fifo_ctrl #(.DEPTH(DB)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_wr_valid(wr_valid), .o_wr_ready(b_wr_ready), .i_wr_data(wr_data),
    .o_rd_valid(b_rd_valid), .i_rd_ready(rd_ready), .o_rd_data(b_rd_data),
    .o_level(b_level), .o_full(b_full), .o_empty(b_empty),
    .o_ram_cen_a(b_cen_a), .o_ram_wen_a(b_wen_a), .o_ram_addr_a(b_addr_a),
    .o_ram_wmsk_a(b_wmsk_a), .o_ram_wdata_a(b_wdata_a),
    .o_ram_cen_b(b_cen_b), .o_ram_wen_b(b_wen_b), .o_ram_addr_b(b_addr_b),
    .o_ram_wmsk_b(b_wmsk_b), .o_ram_wdata_b(b_wdata_b), .i_ram_rdata_b(b_rdata_b)
  );

  // Behavioural RAM macros with a registered read port.
  always @(posedge clk) begin
    if (!a_cen_a && !a_wen_a) mem_a[a_addr_a] <= a_wdata_a;
    if (!a_cen_b) a_rdata_b <= mem_a[a_addr_b];
    if (!b_cen_a && !b_wen_a) mem_b[b_addr_a] <= b_wdata_a;
    if (!b_cen_b) b_rdata_b <= mem_b[b_addr_b];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Scoreboards: sampled on the falling edge, the transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      check_eq("a_rst_wr_ready", a_wr_ready, 0);
      check_eq("a_rst_rd_valid", a_rd_valid, 0);
      check_eq("a_rst_cen_a", a_cen_a, 1);
      check_eq("a_rst_cen_b", a_cen_b, 1);
    end else begin
      check_eq("a_level", a_level, qa.size());
      check_eq("a_wr_ready", a_wr_ready, (qa.size() < DA) ? 1 : 0);
      check_eq("a_full", a_full, (qa.size() == DA) ? 1 : 0);
      check_eq("a_empty", a_empty, (qa.size() == 0) ? 1 : 0);
      check_eq("a_invariant", {21'd0, dut_a.r_level},
               {21'd0, dut_a.r_ram_cnt} + dut_a.r_inflight + dut_a.r_ob_cnt);
      if (a_rd_valid) begin
        if (qa.size() == 0) begin
          check_eq("a_spurious_valid", a_rd_valid, 0);
        end else begin
          check_eq("a_sb_data", a_rd_data, qa[0]);
          if (rd_ready) void'(qa.pop_front());
        end
      end
      if (wr_valid && a_wr_ready) qa.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
      check_eq("b_rst_wr_ready", b_wr_ready, 0);
      check_eq("b_rst_rd_valid", b_rd_valid, 0);
    end else begin
      check_eq("b_level", b_level, qb.size());
      check_eq("b_wr_ready", b_wr_ready, (qb.size() < DB) ? 1 : 0);
      check_eq("b_full", b_full, (qb.size() == DB) ? 1 : 0);
      check_eq("b_empty", b_empty, (qb.size() == 0) ? 1 : 0);
      check_eq("b_invariant", {21'd0, dut_b.r_level},
               {21'd0, dut_b.r_ram_cnt} + dut_b.r_inflight + dut_b.r_ob_cnt);
      if (b_rd_valid) begin
        if (qb.size() == 0) begin
          check_eq("b_spurious_valid", b_rd_valid, 0);
        end else begin
          check_eq("b_sb_data", b_rd_data, qb[0]);
          if (rd_ready) void'(qb.pop_front());
        end
      end
      if (wr_valid && b_wr_ready) qb.push_back(wr_data);
    end
  end

  initial begin
    int exp_v;
    bit seen;

    // 1. Reset values with wr_valid held high.
    rst = 1'b1;
    wr_valid = 1'b1;
    wr_data = 18'h3FFFF;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst_wr_ready", a_wr_ready, 0);
      check_eq("rst_rd_valid", a_rd_valid, 0);
      check_eq("rst_level", a_level, 0);
      check_eq("rst_empty", a_empty, 1);
      check_eq("rst_full", a_full, 0);
      check_eq("rst_rd_data", a_rd_data, 0);
      check_eq("rst_cen_a", a_cen_a, 1);
      check_eq("rst_wen_a", a_wen_a, 1);
      check_eq("rst_cen_b", a_cen_b, 1);
    end
    rst = 1'b0;
    wr_valid = 1'b0;
    step();

    // 2. Single-word latency.
    wr_valid = 1'b1;
    wr_data = 18'h2A5F5;
    step();
    wr_valid = 1'b0;
    check_eq("lat_level", a_level, 1);
    check_eq("lat_valid_n0", a_rd_valid, 0);
    step();
    check_eq("lat_valid_n1", a_rd_valid, 0);
    step();
    check_eq("lat_valid_n2", a_rd_valid, 1);
    check_eq("lat_data", a_rd_data, 18'h2A5F5);
    check_eq("lat_level2", a_level, 1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check_eq("lat_empty", a_empty, 1);
    check_eq("lat_valid_after_pop", a_rd_valid, 0);

    // 3. Fill and drain at DEPTH=1024.
    do_reset();
    for (int i = 0; i < DA; i++) begin
      wr_valid = 1'b1;
      wr_data = 18'(i);
      step();
    end
    wr_data = 18'd1024;
    check_eq("fill_level", a_level, 1024);
    check_eq("fill_full", a_full, 1);
    check_eq("fill_wr_ready", a_wr_ready, 0);
    step();
    check_eq("fill_refused_level", a_level, 1024);
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    exp_v = 0;
    for (int n = 0; n < 1200 && exp_v < DA; n++) begin
      if (a_rd_valid) begin
        check_eq("drain_data", a_rd_data, exp_v);
        exp_v++;
      end
      step();
    end
    rd_ready = 1'b0;
    check_eq("drain_count", exp_v, DA);
    check_eq("drain_empty", a_empty, 1);
    check_eq("drain_full", a_full, 0);

    // 4. Streaming across wrap at DEPTH=10.
    do_reset();
    rd_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      wr_valid = 1'b1;
      wr_data = 18'(k);
      step();
      check_eq("stream_level_le3", (b_level <= 11'd3) ? 1 : 0, 1);
      if (k >= 2) begin
        check_eq("stream_valid", b_rd_valid, 1);
        check_eq("stream_data", b_rd_data, k - 2);
      end
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check_eq("stream_empty", b_empty, 1);
    rd_ready = 1'b0;

    // 5. Random backpressure; the scoreboards do the checking.
    do_reset();
    for (int k = 0; k < 5000; k++) begin
      wr_valid = 1'($urandom_range(0, 1));
      rd_ready = 1'($urandom_range(0, 1));
      wr_data  = 18'($urandom);
      step();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int k = 0; k < 1100; k++) step();
    check_eq("rand_drained_a", a_empty, 1);
    check_eq("rand_drained_b", b_empty, 1);
    rd_ready = 1'b0;

    // 6. Reset mid-operation with a read in flight at level 5.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data = 18'h100 + 18'(i);
      step();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check_eq("mid_level5", a_level, 5);
    check_eq("mid_inflight", dut_a.r_inflight, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_level", a_level, 0);
    check_eq("mid_rst_valid", a_rd_valid, 0);
    wr_valid = 1'b1;
    wr_data = 18'h00001;
    step();
    wr_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      if (a_rd_valid) seen = 1'b1;
      else step();
    end
    check_eq("mid_seen", seen, 1);
    check_eq("mid_data", a_rd_data, 18'h00001);
    check_eq("mid_level1", a_level, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
